// File: rtl/max_pool2x2.sv
// Streaming 2x2 max-pooling over a raster image into a held pooled array.
// The array is frozen with pool_done high until the consumer acknowledges with out_ack.
module max_pool2x2 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  localparam int N_OUT = (IMG_W / 2) * (IMG_H / 2)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pix_valid,
  input  logic                    pix_sof,
  input  logic signed [IN_W-1:0]  pix_in,
  output logic                    pix_ready,
  input  logic                    out_ack,
  output logic signed [OUT_W-1:0] pooled_img [0:N_OUT-1],
  output logic                    pool_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int HW = IMG_W / 2;

  logic [CW-1:0]          col_q, col_d, col_e;
  logic [RW-1:0]          row_q, row_d, row_e;
  logic                   done_q, done_d;
  logic signed [IN_W-1:0] pair_q;
  logic signed [IN_W-1:0] lb_q [0:HW-1];
  logic signed [IN_W-1:0] m, lb_rd;
  logic                   accept, last_col, last_row;
  int                     hc, idx;

  function automatic logic signed [IN_W-1:0] smax(input logic signed [IN_W-1:0] a,
                                                   input logic signed [IN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [OUT_W-1:0] sext(input logic signed [IN_W-1:0] x);
    return OUT_W'(x);
  endfunction

  assign pix_ready = ~done_q;
  assign pool_done = done_q;

  always_comb begin
    accept   = pix_valid && !done_q;
    // An accepted sof pins this pixel to the frame origin regardless of the counters.
    col_e    = pix_sof ? '0 : col_q;
    row_e    = pix_sof ? '0 : row_q;
    last_col = (col_e == CW'(IMG_W - 1));
    last_row = (row_e == RW'(IMG_H - 1));
    hc       = int'(col_e >> 1);
    idx      = int'(row_e >> 1) * HW + hc;
    lb_rd    = '0;
    for (int k = 0; k < HW; k++) begin
      if (k == hc) lb_rd = lb_q[k];
    end
    m      = smax(pair_q, pix_in);
    col_d  = col_q;
    row_d  = row_q;
    done_d = done_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_e + RW'(1);
      end else begin
        col_d = col_e + CW'(1);
        row_d = row_e;
      end
      if (last_col && last_row) done_d = 1'b1;
    end else if (done_q && out_ack) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      done_q <= 1'b0;
      pair_q <= '0;
      for (int k = 0; k < HW; k++) lb_q[k] <= '0;
      for (int k = 0; k < N_OUT; k++) pooled_img[k] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      done_q <= done_d;
      if (accept) begin
        if (!col_e[0]) begin
          pair_q <= pix_in;
        end else if (!row_e[0]) begin
          for (int k = 0; k < HW; k++) begin
            if (k == hc) lb_q[k] <= m;
          end
        end else begin
          for (int k = 0; k < N_OUT; k++) begin
            if (k == idx) pooled_img[k] <= sext(smax(lb_rd, m));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool2x2.sv
// Randomized bench for max_pool2x2: block-max reference model feeding a frame scoreboard.
module tb_max_pool2x2;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int NO = 196;

  logic               clk = 1'b0;
  logic               reset, pix_valid, pix_sof, out_ack;
  logic signed [7:0]  pix_in;
  logic               pix_ready, pool_done;
  logic signed [15:0] pooled_img [0:NO-1];

  max_pool2x2 #(.IMG_W(W), .IMG_H(H), .IN_W(8), .OUT_W(16)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_in(pix_in), .pix_ready(pix_ready), .out_ack(out_ack),
    .pooled_img(pooled_img), .pool_done(pool_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int img [0:H-1][0:W-1];
  int digit [0:NO-1];
  int last_exp [0:NO-1];
  int exp_q [$];
  int acc_cnt = 0;
  bit last_acc = 1'b0;
  bit prev_done = 1'b0;

  // Reference: each output is the plain maximum of its 2x2 input block.
  task automatic push_expected();
    int mx;
    for (int br = 0; br < H / 2; br++) begin
      for (int bc = 0; bc < W / 2; bc++) begin
        mx = img[2*br][2*bc];
        if (img[2*br][2*bc+1] > mx) mx = img[2*br][2*bc+1];
        if (img[2*br+1][2*bc] > mx) mx = img[2*br+1][2*bc];
        if (img[2*br+1][2*bc+1] > mx) mx = img[2*br+1][2*bc+1];
        exp_q.push_back(mx);
        last_exp[br*(W/2)+bc] = mx;
      end
    end
  endtask

  // Monitor: scores each completed frame when pool_done rises.
  always @(negedge clk) begin
    int bad, be, ba, e;
    if (pool_done && !prev_done) begin
      bad = -1; be = 0; ba = 0;
      tests++;
      if (exp_q.size() < NO) begin
        fails++;
        $display("FAIL frame_avail: queued=%0d required=%0d", exp_q.size(), NO);
      end else begin
        for (int k = 0; k < NO; k++) begin
          e = exp_q.pop_front();
          if (int'(pooled_img[k]) != e && bad < 0) begin
            bad = k; be = e; ba = int'(pooled_img[k]);
          end
        end
        if (bad >= 0) begin
          fails++;
          $display("FAIL frame_data: entry %0d actual=%0d required=%0d", bad, ba, be);
        end
      end
      tests++;
      if (!(last_acc && acc_cnt == W * H)) begin
        fails++;
        $display("FAIL done_latency: acceptances=%0d last_cycle_acc=%0b required=%0d,1",
                 acc_cnt, last_acc, W * H);
      end
    end
    prev_done = pool_done;
    if (reset) begin
      acc_cnt  = 0;
      last_acc = 1'b0;
    end else begin
      last_acc = pix_valid && pix_ready;
      if (last_acc) acc_cnt = pix_sof ? 1 : acc_cnt + 1;
    end
  end

  task automatic stream(input int npix, input bit bubbles);
    int n, guard;
    bit acc;
    n = 0; guard = 0;
    while (n < npix && guard < 5000) begin
      pix_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      pix_in    = 8'(img[n / W][n % W]);
      pix_sof   = (n == 0);
      acc       = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (acc) n++;
      guard++;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    if (n < npix) begin
      tests++; fails++;
      $display("FAIL stream_timeout: accepted=%0d required=%0d", n, npix);
    end
  endtask

  task automatic wait_done(input string name);
    int g;
    g = 0;
    while (!pool_done && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    tests++;
    if (!pool_done) begin
      fails++;
      $display("FAIL %s: pool_done actual=0 required=1", name);
    end
  endtask

  task automatic ack();
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    tests++;
    if (pool_done !== 1'b0 || pix_ready !== 1'b1) begin
      fails++;
      $display("FAIL release: done=%b ready=%b required done=0 ready=1", pool_done, pix_ready);
    end
  endtask

  task automatic check_entry(input string name, input int k, input logic [15:0] exp);
    tests++;
    if (pooled_img[k] !== exp) begin
      fails++;
      $display("FAIL %s: entry %0d actual=%h required=%h", name, k, pooled_img[k], exp);
    end
  endtask

  task automatic check_cleared(input string name);
    bit ok;
    ok = (pool_done === 1'b0) && (pix_ready === 1'b1);
    for (int k = 0; k < NO; k++) if (pooled_img[k] !== 16'h0) ok = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: done=%b ready=%b entry0=%h required done=0 ready=1 all zero",
               name, pool_done, pix_ready, pooled_img[0]);
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = (r * W + c) % 128;
  endtask

  task automatic fill_digit();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = digit[(r / 2) * (W / 2) + c / 2];
  endtask

  initial begin
    bit ok;
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0; out_ack = 1'b0;
    for (int k = 0; k < NO; k++) digit[k] = int'($urandom_range(0, 255)) - 128;
    digit[33] = 11; digit[34] = 58; digit[48] = 127;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_cleared("reset_state");

    fill_ramp(); push_expected(); stream(W * H, 1'b0);
    wait_done("ramp_done");
    check_entry("ramp_e0", 0, 16'd29);
    check_entry("ramp_e1", 1, 16'd31);
    check_entry("ramp_e13", 13, 16'd55);
    check_entry("ramp_e14", 14, 16'd85);
    ack();

    fill_digit(); push_expected(); stream(W * H, 1'b1);
    wait_done("digit_done");
    check_entry("digit_e33", 33, 16'd11);
    check_entry("digit_e34", 34, 16'd58);
    check_entry("digit_e48", 48, 16'd127);
    ack();

    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = -128;
    for (int b = 0; b < NO; b++)
      img[2 * (b / (W / 2)) + (b % 4) / 2][2 * (b % (W / 2)) + (b % 4) % 2] = -1;
    push_expected(); stream(W * H, 1'b1);
    wait_done("neg1_done");
    check_entry("neg1_e0", 0, 16'hFFFF);
    check_entry("neg1_e195", 195, 16'hFFFF);
    ack();

    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = -128;
    push_expected(); stream(W * H, 1'b0);
    wait_done("neg128_done");
    check_entry("neg128_e7", 7, 16'hFF80);

    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'b1; pix_in = 8'd100; pix_sof = i[0];
      @(posedge clk); #1;
      ok = (pix_ready === 1'b0) && (pool_done === 1'b1);
      for (int k = 0; k < NO; k++) if (int'(pooled_img[k]) != last_exp[k]) ok = 1'b0;
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL hold_%0d: ready=%b done=%b entry0=%h required ready=0 done=1 frozen",
                 i, pix_ready, pool_done, pooled_img[0]);
      end
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    ack();

    fill_ramp(); push_expected(); stream(W * H, 1'b1);
    wait_done("second_done");
    check_entry("second_e14", 14, 16'd85);

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_cleared("reset_in_hold");

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255)) - 128;
    push_expected(); stream(W * H, 1'b1);
    wait_done("random_done");
    ack();

    fill_ramp(); stream(400, 1'b0);
    fill_digit(); push_expected(); stream(W * H, 1'b1);
    wait_done("resync_done");
    check_entry("resync_e33", 33, 16'd11);
    check_entry("resync_e48", 48, 16'd127);
    ack();

    repeat (2) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: leftover=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/max_pool2x2.md
Name: max_pool2x2

Overview:
- Streaming 2x2 max-pooling stage ahead of dense_layer1.
- Accepts a raster-order image one pixel per cycle (default 28x28) and writes the pooled image (default 14x14 = 196 entries) into a held output array, which feeds pooled_img of dense_layer1 directly.
- Signals frame completion with pool_done, which drives the dense layer's enable.
- Holds the array stable until the consumer acknowledges.

Parameters:
IMG_W, 28, input image width in pixels; even, >= 2
IMG_H, 28, input image height in pixels; even, >= 2
IN_W, 8, input pixel width, signed
OUT_W, 16, output entry width, signed; OUT_W >= IN_W
(derived) N_OUT = (IMG_W/2)*(IMG_H/2), default 196

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
pix_valid  input  1  pix_in is valid this cycle
pix_sof  input  1  qualifies pix_in as the first pixel of a frame (row 0, col 0)
pix_in  input  IN_W  signed pixel, raster order, row-major
pix_ready  output  1  block can accept a pixel this cycle
out_ack  input  1  consumer has finished reading pooled_img
pooled_img  output  OUT_W x N_OUT  unpacked array [0:N_OUT-1], signed, registered
pool_done  output  1  level; pooled_img holds a complete frame

Behaviour:
- Reset values: pooled_img all 0; pool_done 0; pix_ready 1; col, row counters 0; line buffer and pair register 0.
- Reset mid-frame aborts the frame. Partial writes are cleared to 0.
- Accept: a pixel is accepted when pix_valid && pix_ready. Bubbles (pix_valid=0) are allowed anywhere; no state changes on non-accept cycles.
- Counters:
  - col runs 0..IMG_W-1. It wraps to 0 and increments row.
  - row runs 0..IMG_H-1. It wraps to 0 after the last pixel.
- pix_sof on an accepted pixel forces that pixel to be treated as row 0, col 0, whatever the counter values. A mid-frame sof abandons the partial frame. Entries already written stay until overwritten. pix_sof without pix_valid is ignored.
- Datapath, all comparisons signed:
  - Even col: pair register <= pix_in.
  - Odd col: m = max(pair register, pix_in).
  - Even row, odd col: line buffer[col/2] <= m.
  - Odd row, odd col: pooled_img[(row/2)*(IMG_W/2) + col/2] <= sign-extend(max(line buffer[col/2], m)) to OUT_W.
- Latency: each pooled entry is visible in pooled_img the cycle after its block's bottom-right pixel is accepted.
- Done:
  - On acceptance of pixel (IMG_H-1, IMG_W-1), pool_done goes to 1 in the same cycle that the final entry becomes visible.
  - pix_ready goes to 0 in that same cycle.
- Hold: while pool_done=1 and out_ack=0:
  - pix_ready stays 0.
  - Pixels are not accepted; pix_sof is also ignored.
  - pooled_img is frozen.
- Release: on out_ack=1 while pool_done=1, pool_done goes to 0 and pix_ready to 1 on the next cycle. The next frame may start that cycle.
- out_ack while pool_done=0 is ignored.
- Simultaneous reset and out_ack: reset wins.
- pooled_img is not cleared between frames. Each frame fully overwrites all N_OUT entries.
- States, encoded implicitly:
  - IDLE/STREAM: pool_done=0, pix_ready=1.
  - HOLD: pool_done=1, pix_ready=0.
  - STREAM->HOLD on the last pixel; HOLD->STREAM on out_ack; any state -> STREAM on reset.
- A single frame needs exactly IMG_W*IMG_H accepted pixels. There is no end-of-frame input.

Test Plan:
1. Reset: assert reset 3 cycles -> pooled_img all 0, pool_done 0, pix_ready 1. Pulse reset during HOLD -> pool_done 0, pix_ready 1 next cycle.
2. Ramp frame: pixel(r,c) = (r*28+c) mod 128, sof on the first pixel, no bubbles.
   - pool_done rises exactly 1 cycle after the 784th acceptance.
   - Entry 0 = 29, entry 1 = 31, entry 13 = 55, entry 14 = 85.
3. Digit upsample: each of the 196 values of the team's reference digit vector is replicated into a 2x2 block, with random pix_valid bubbles.
   - pooled_img equals the original vector, e.g. index 33 = 11, index 34 = 58, index 48 = 127.
4. Signed/extension: all pixels -128, plus one pixel per block = -1 at a rotating position -> every entry = 16'hFFFF.
   - All pixels -128 -> every entry = 16'hFF80.
5. Backpressure: after done, hold out_ack=0 for 10 cycles with pix_valid=1 and pixel value 100 -> pix_ready 0, pooled_img unchanged, pool_done 1.
   - Pulse out_ack -> pool_done 0 and pix_ready 1 next cycle.
   - The second frame is correct.
6. Resync: send 400 pixels of the ramp, then assert pix_sof with the digit frame -> final pooled_img equals the digit result.
   - Exactly 784 acceptances follow the sof before pool_done rises.
